// File: rtl/fp_int_mac_if.sv
// Bus bundle for fp_int_mac: serial weight feed, activation, block-exponent
// preload and the registered fixed-point result.
interface fp_int_mac_if #(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32
);
  logic                 valid;
  logic [3:0]           precision;
  logic                 set;
  logic [ACT_WIDTH-1:0] act;
  logic                 w;
  logic [4:0]           exp_set;
  logic [ACC_WIDTH-1:0] fixed_point_acc;
  logic [4:0]           exp_out;
  logic [ACC_WIDTH-1:0] fixed_point_out;
  logic                 done;

  modport master (
    output valid, precision, set, act, w, exp_set, fixed_point_acc,
    input  exp_out, fixed_point_out, done
  );

  modport slave (
    input  valid, precision, set, act, w, exp_set, fixed_point_acc,
    output exp_out, fixed_point_out, done
  );
endinterface

// File: rtl/fp_int_mac.sv
// Bit-serial FP16 x sign-magnitude integer MAC: the product is aligned to a
// shared block exponent and added to a preloaded two's-complement base.
module fp_int_mac #(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  fp_int_mac_if.slave  bus
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic [3:0]           n_reg, n_nx;
  logic                 ws, ws_nx;
  logic [13:0]          mag, mag_nx;
  logic [4:0]           exp_reg, exp_nx;
  logic [ACC_WIDTH-1:0] base_reg, base_nx;
  logic [ACC_WIDTH-1:0] out_reg, out_nx;
  logic                 done_reg, done_nx;

  // Datapath evaluated every cycle; only committed on the last weight bit.
  logic [13:0]          mag_shift;
  logic                 act_sign;
  logic [4:0]           e_raw, e_eff;
  logic [10:0]          sig;
  logic [24:0]          prod;
  logic signed [6:0]    d;
  logic [6:0]           neg_d;
  logic [ACC_WIDTH-1:0] prod_ext, aligned, value;
  logic [3:0]           n_latch;

  assign mag_shift = {mag[12:0], bus.w};
  assign act_sign  = bus.act[ACT_WIDTH-1];
  assign e_raw     = bus.act[14:10];
  // Subnormals use the implicit exponent 1 with a zero hidden bit.
  assign e_eff     = (e_raw == 5'd0) ? 5'd1 : e_raw;
  assign sig       = {(e_raw != 5'd0), bus.act[9:0]};
  assign prod      = 25'(sig) * 25'(mag_shift);
  assign d         = $signed({2'b00, e_eff}) - $signed({2'b00, exp_reg});
  assign neg_d     = 7'(-d);
  assign prod_ext  = ACC_WIDTH'(prod);
  assign aligned   = d[6] ? (prod_ext >> neg_d[5:0]) : (prod_ext << d[5:0]);
  assign value     = (act_sign ^ ws) ? (~aligned + 1'b1) : aligned;
  assign n_latch   = (bus.precision < 4'd2) ? 4'd2 : bus.precision;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    n_nx     = n_reg;
    ws_nx    = ws;
    mag_nx   = mag;
    exp_nx   = exp_reg;
    base_nx  = base_reg;
    out_nx   = out_reg;
    done_nx  = 1'b0;

    if (bus.set) begin
      exp_nx   = bus.exp_set;
      base_nx  = bus.fixed_point_acc;
      cnt_nx   = 4'd0;
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.valid) begin
            n_nx     = n_latch;
            ws_nx    = bus.w;
            mag_nx   = 14'd0;
            cnt_nx   = 4'd1;
            state_nx = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!bus.valid) begin
            cnt_nx   = 4'd0;
            state_nx = S_IDLE;
          end else begin
            mag_nx = mag_shift;
            if (cnt == 4'(n_reg - 4'd1)) begin
              out_nx   = base_reg + value;
              done_nx  = 1'b1;
              cnt_nx   = 4'd0;
              state_nx = S_IDLE;
            end else begin
              cnt_nx = 4'(cnt + 4'd1);
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      n_reg    <= 4'd2;
      ws       <= 1'b0;
      mag      <= '0;
      exp_reg  <= '0;
      base_reg <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      n_reg    <= n_nx;
      ws       <= ws_nx;
      mag      <= mag_nx;
      exp_reg  <= exp_nx;
      base_reg <= base_nx;
      out_reg  <= out_nx;
      done_reg <= done_nx;
    end
  end

  assign bus.exp_out         = exp_reg;
  assign bus.fixed_point_out = out_reg;
  assign bus.done            = done_reg;

endmodule

// File: tb/tb_fp_int_mac.sv
// Scoreboard bench for fp_int_mac: directed groups push hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_fp_int_mac;

  logic clk = 1'b0;
  logic rst;

  fp_int_mac_if #(.ACT_WIDTH(16), .ACC_WIDTH(32)) bus ();

  fp_int_mac #(.ACT_WIDTH(16), .ACC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fp;
    logic [4:0]  ex;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  cur_exp = 5'd0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: fixed_point_out 0x%08h with nothing expected",
                 bus.fixed_point_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fixed_point_out", bus.fixed_point_out, e.fp);
        check("exp_out_at_done", {27'd0, bus.exp_out}, {27'd0, e.ex});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.valid = 1'b1;
    bus.w     = b;
    tick();
    bus.valid = 1'b0;
  endtask

  task automatic do_set(input logic [4:0] e, input logic [31:0] base,
                        input logic with_valid);
    bus.set             = 1'b1;
    bus.exp_set         = e;
    bus.fixed_point_acc = base;
    bus.valid           = with_valid;
    bus.w               = 1'b1;
    tick();
    bus.set   = 1'b0;
    bus.valid = 1'b0;
    cur_exp   = e;
  endtask

  task automatic send_group(input logic [15:0] a, input logic [3:0] prec,
                            input int n, input logic [14:0] bits,
                            input logic [31:0] expected);
    exp_t e;
    e.fp = expected;
    e.ex = cur_exp;
    sb.push_back(e);
    bus.act       = a;
    bus.precision = prec;
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i]);
  endtask

  task automatic partial(input int n);
    bus.act       = 16'h4569;
    bus.precision = 4'd4;
    for (int i = 0; i < n; i++) drive_bit(i[0]);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.valid           = 1'b0;
    bus.precision       = 4'd4;
    bus.set             = 1'b0;
    bus.act             = 16'h0000;
    bus.w               = 1'b0;
    bus.exp_set         = 5'd0;
    bus.fixed_point_acc = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_exp_out", {27'd0, bus.exp_out}, 32'd0);
    check("reset_fp_out", bus.fixed_point_out, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    tick();

    do_set(5'd16, 32'd2, 1'b0);
    @(negedge clk);
    check("exp_out_after_set", {27'd0, bus.exp_out}, 32'd16);
    tick();

    // Back-to-back groups under continuous valid.
    send_group(16'h4569, 4'd4, 4, 15'b0101, 32'd13852);
    send_group(16'h4AAA, 4'd4, 4, 15'b1010, 32'hFFFFCAB2);
    send_group(16'h1234, 4'd4, 4, 15'b0000, 32'd2);
    send_group(16'h4569, 4'd4, 4, 15'b1000, 32'd2);
    send_group(16'h3C00, 4'd4, 4, 15'b0001, 32'd514);
    send_group(16'hC569, 4'd4, 4, 15'b0001, 32'hFFFFF530);
    send_group(16'h3C00, 4'd0, 2, 15'b11, 32'hFFFFFE02);
    send_group(16'h3C00, 4'd15, 15, 15'b011111111111111, 32'h007FFE02);
    tick();

    // valid drop after two bits discards the partial group.
    partial(2);
    tick();
    send_group(16'h4569, 4'd4, 4, 15'b0101, 32'd13852);
    tick();

    // set mid-group (with valid high) aborts and installs a new base.
    partial(2);
    do_set(5'd16, 32'd1000, 1'b1);
    send_group(16'h4569, 4'd4, 4, 15'b0001, 32'd3770);
    tick();

    // Subnormal activation and a wrapping 31-bit left shift.
    do_set(5'd0, 32'd100, 1'b0);
    send_group(16'h0003, 4'd4, 4, 15'b0111, 32'd142);
    send_group(16'h7C01, 4'd4, 4, 15'b0001, 32'h80000064);
    tick();

    // Reset mid-group clears everything without a done.
    partial(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_exp_out", {27'd0, bus.exp_out}, 32'd0);
    check("rst_mid_fp_out", bus.fixed_point_out, 32'd0);
    check("rst_mid_done", {31'd0, bus.done}, 32'd0);
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_int_mac.md
# fp_int_mac

Bit-serial multiply-accumulate element for mixed-precision inference. It multiplies an FP16 activation by a sign-magnitude integer weight that arrives one bit per cycle, MSB first. The product is aligned to a shared block exponent and added to a preloaded fixed-point base. It sits in the PE array between the FP16 activation feed and the block-floating-point accumulator path.

## Interface
- ACT_WIDTH, 16: activation width (FP16: 1 sign, 5 exponent, 10 mantissa bits)
- ACC_WIDTH, 32: fixed-point accumulator and result width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid  in  1  weight bit `w` is valid this cycle
- precision  in  4  weight bits per group (sign + magnitude), range 2..15; values 0/1 treated as 2
- set  in  1  load `exp_set` and `fixed_point_acc` into internal registers
- act  in  ACT_WIDTH  FP16 activation; held stable for a whole weight group
- w  in  1  serial weight bit, MSB (sign) first
- exp_set  in  5  shared block exponent (biased, same encoding as FP16 exponent)
- fixed_point_acc  in  ACC_WIDTH  base accumulator value, two's complement
- exp_out  out  5  registered block exponent
- fixed_point_out  out  ACC_WIDTH  result, two's complement
- done  out  1  one-cycle pulse when `fixed_point_out` is updated

## Operation
- `set`=1: `exp_reg`<=`exp_set`; `base_reg`<=`fixed_point_acc`; the bit counter clears, which aborts any partial group. `set` has priority over `valid`.
- `exp_out` always equals `exp_reg`.
- Group start (counter=0, `valid`=1):
  - latch `N=max(precision,2)`;
  - the first bit is the weight sign `ws`;
  - magnitude register clears.
- The next N-1 valid cycles shift magnitude in: `mag<=(mag<<1)|w`.
- On the cycle the last bit is sampled:
  - sample `act`: `s`=act[15], `e`=act[14:10], `f`=act[9:0];
  - significand `m`: `{1,f}` when `e`!=0; `{0,f}` with `e` treated as 1 when `e`=0 (subnormal);
  - Inf/NaN (`e`=31) are treated as normal numbers;
  - `P=m*mag` (unsigned, up to 25 bits);
  - `d=e-exp_reg`: if `d`>=0, `P<<d`; if `d`<0, `P>>-d` (truncate magnitude); take the result modulo 2^32; shifts of 32 or more give 0;
  - negate the aligned value if `s^ws`=1;
  - `fixed_point_out`<=`base_reg`+value, wrapping modulo 2^32;
  - `done`<=1; counter returns to 0.
- Each group result is `base + act*w`, not a running sum across groups. `base_reg` changes only on `set`.
- `valid`=0 mid-group: the partial group is discarded and the counter clears. No `done`; outputs hold.
- Weight magnitude 0 gives `fixed_point_out`=`base_reg`, even when the sign bit is set.

## Timing
- Reset values: `exp_out`=0, `fixed_point_out`=0, `done`=0; `exp_reg`, `base_reg` and the counter all clear.
- Bits are sampled on the rising edges where `valid`=1.
- Latency: `done` and the new `fixed_point_out` are visible in the cycle after the edge that samples the last bit.
- Back-to-back groups: the first bit of the next group may be sampled in the same cycle `done` is high. `done` pulses every N cycles under continuous `valid`.
- `done` is high for exactly one cycle. `fixed_point_out` holds until the next `done` or reset.
- `exp_out` updates the cycle after `set`.
- `rst` mid-group: everything clears on that edge and no `done` is produced.
- `set` and `rst` together: `rst` wins.

## Test plan
- Reset: `rst`=1 for 1 cycle -> `exp_out`=0, `fixed_point_out`=0, `done`=0.
- `set` with `exp_set`=16, `fixed_point_acc`=2; precision=4, `act`=0x4569, `w`=0,1,0,1 -> `done` pulse, `exp_out`=16, `fixed_point_out`=13852 (2+5*2770).
- Same base; `act`=0x4AAA, `w`=1,0,1,0 -> `fixed_point_out`=0xFFFFCAB2 (2-2*6824).
- Same base; any `act`, `w`=0,0,0,0 -> `fixed_point_out`=2.
- Right shift and negative activation: `act`=0x3C00, `w`=0,0,0,1 -> 514; `act`=0xC569, `w`=0,0,0,1 -> 0xFFFFF530 (-2768).
- Abort: drop `valid` after 2 bits, then send a full 4-bit group -> no `done` for the partial group; exactly one `done` with the full-group result. Repeat with `set` asserted mid-group: the group is aborted and the new base is used.
